// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: state encodings and width helpers shared by the pulse stretcher
package pulse_stretcher_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, GAP = 2'd2} state_t;
  function automatic int pending_width(input int max_pending);
    return $clog2(max_pending + 1);
  endfunction
  function automatic int timer_width(input int pulse_period, input int gap_period);
    int m;
    m = pulse_period > gap_period ? pulse_period : gap_period;
    return $clog2(m < 2 ? 2 : m);
  endfunction
endpackage

// File: rtl/pulse_stretcher_sat_updown_counter.sv
// sat_updown_counter: up/down counter that holds at MAX and at zero
module sat_updown_counter #(
  parameter int WIDTH = 4,
  parameter int MAX = 15
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count,
  output logic             at_max
);
  assign at_max = count == WIDTH'(MAX);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) count <= '0;
    else if (inc && !dec && !at_max) count <= count + WIDTH'(1);
    else if (dec && !inc && count != '0) count <= count - WIDTH'(1);
endmodule

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns event strobes into minimum-width pulses with a guaranteed idle gap
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int   PULSE_PERIOD = 256,
  parameter int   GAP_PERIOD   = 256,
  parameter int   MAX_PENDING  = 15,
  parameter logic IDLE_VALUE   = 1'b0,
  localparam int  PW = pending_width(MAX_PENDING),
  localparam int  TW = timer_width(PULSE_PERIOD, GAP_PERIOD)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          event_i,
  input  logic          clear_overflow,
  output logic          data_o,
  output logic          busy,
  output logic [PW-1:0] pending,
  output logic          overflow
);
  state_t        state, next_state;
  logic [TW-1:0] timer, next_timer;
  logic          launch, at_max;
  assign launch = enable && state == IDLE && pending != '0;
  assign busy = state != IDLE || pending != '0;
  sat_updown_counter #(.WIDTH(PW), .MAX(MAX_PENDING)) u_pending (
    .clock(clock), .reset_n(reset_n), .inc(event_i), .dec(launch),
    .count(pending), .at_max(at_max)
  );
  always_comb begin
    next_state = !enable ? state :
                 state == IDLE   ? (pending != '0 ? ACTIVE : IDLE) :
                 state == ACTIVE ? (timer == '0 ? (GAP_PERIOD == 0 ? IDLE : GAP) : ACTIVE) :
                 state == GAP    ? (timer == '0 ? IDLE : GAP) : IDLE;
    next_timer = launch ? TW'(PULSE_PERIOD - 1) :
                 (!enable || state == IDLE) ? timer :
                 timer != '0 ? timer - TW'(1) :
                 (state == ACTIVE && GAP_PERIOD != 0) ? TW'(GAP_PERIOD - 1) : '0;
  end
  // data_o follows next_state so the pin moves on the same edge as the FSM
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      timer    <= '0;
      data_o   <= IDLE_VALUE;
      overflow <= 1'b0;
    end else begin
      state    <= next_state;
      timer    <= next_timer;
      data_o   <= next_state == ACTIVE ? ~IDLE_VALUE : IDLE_VALUE;
      overflow <= (event_i && at_max && !launch) || (overflow && !clear_overflow);
    end
endmodule

// File: tb/tb_pulse_stretcher.sv
// tb_pulse_stretcher: directed stimulus with a pulse scoreboard for pulse_stretcher
module tb_pulse_stretcher;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic       event_i = 1'b0;
  logic       clear_overflow = 1'b0;
  logic       data_o, busy, overflow;
  logic [1:0] pending;
  int checks = 0;
  int passed = 0;
  typedef struct {int width; int gap;} exp_t;
  exp_t q[$];

  pulse_stretcher #(.PULSE_PERIOD(4), .GAP_PERIOD(2), .MAX_PENDING(3), .IDLE_VALUE(1'b0)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .event_i(event_i),
    .clear_overflow(clear_overflow), .data_o(data_o), .busy(busy),
    .pending(pending), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic expect_pulse(input int width, input int gap);
    exp_t e;
    e.width = width;
    e.gap = gap;
    q.push_back(e);
  endtask

  // Monitor: measures each completed pulse and its preceding low time
  logic prev = 1'b0;
  int hi_len = 0, lo_len = 0, cur_gap = -1;
  bit lo_valid = 0;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev = 1'b0;
      hi_len = 0;
      lo_valid = 0;
    end else begin
      if (data_o) begin
        if (!prev) begin
          cur_gap = lo_valid ? lo_len : -1;
          hi_len = 0;
        end
        hi_len++;
      end else begin
        if (prev) begin
          if (q.size() == 0) check("unexpected_pulse", 1, 0);
          else begin
            exp_t e;
            e = q.pop_front();
            check("pulse_width", hi_len, e.width);
            if (e.gap > 0) check("pulse_gap", cur_gap, e.gap);
          end
          lo_len = 0;
          lo_valid = 1;
        end
        lo_len++;
      end
      prev = data_o;
    end
  end

  initial begin
    @(negedge clock);
    @(negedge clock);
    check("reset_data_o", data_o, 0);
    check("reset_busy", busy, 0);
    check("reset_pending", pending, 0);
    check("reset_overflow", overflow, 0);
    reset_n = 1'b1;
    enable = 1'b1;
    step(2);

    // single event
    expect_pulse(4, 0);
    event_i = 1'b1;
    step();
    event_i = 1'b0;
    check("single_pending", pending, 1);
    check("single_data_pre", data_o, 0);
    step();
    check("single_data_edge1", data_o, 1);
    step(5);
    check("single_busy_edge6", busy, 1);
    step();
    check("single_busy_edge7", busy, 0);

    // three events back to back
    expect_pulse(4, 0);
    expect_pulse(4, 3);
    expect_pulse(4, 3);
    event_i = 1'b1;
    step(3);
    event_i = 1'b0;
    check("burst_pending_edge2", pending, 2);
    step(12);
    check("burst_pending_edge14", pending, 1);
    step();
    check("burst_pending_edge15", pending, 0);
    check("burst_busy_edge15", busy, 1);
    step(6);
    check("burst_busy_done", busy, 0);

    // saturation while disabled
    enable = 1'b0;
    event_i = 1'b1;
    step(3);
    check("sat_pending_3", pending, 3);
    check("sat_overflow_3", overflow, 0);
    step();
    check("sat_pending_4", pending, 3);
    check("sat_overflow_4", overflow, 1);
    step();
    check("sat_pending_5", pending, 3);
    event_i = 1'b0;
    expect_pulse(4, 0);
    expect_pulse(4, 3);
    expect_pulse(4, 3);
    enable = 1'b1;
    step(21);
    check("sat_busy_done", busy, 0);
    check("sat_outstanding", q.size(), 0);

    // overflow set beats clear
    clear_overflow = 1'b1;
    step();
    clear_overflow = 1'b0;
    check("clr_alone_first", overflow, 0);
    enable = 1'b0;
    event_i = 1'b1;
    step(4);
    check("clr_sat_overflow", overflow, 1);
    clear_overflow = 1'b1;
    step();
    check("clr_vs_set", overflow, 1);
    check("clr_vs_set_pending", pending, 3);
    event_i = 1'b0;
    step();
    clear_overflow = 1'b0;
    check("clr_alone", overflow, 0);
    expect_pulse(4, 0);
    expect_pulse(4, 3);
    expect_pulse(4, 3);
    enable = 1'b1;
    step(21);
    check("clr_busy_done", busy, 0);

    // enable toggling stretches the pulse to 8 clocks
    expect_pulse(8, 0);
    event_i = 1'b1;
    step();
    event_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      enable = (i % 2 == 0);
      step();
    end
    enable = 1'b1;
    step();
    check("toggle_busy_done", busy, 0);
    check("toggle_outstanding", q.size(), 0);

    // asynchronous reset mid-pulse
    enable = 1'b0;
    event_i = 1'b1;
    step(4);
    event_i = 1'b0;
    enable = 1'b1;
    step(2);
    check("abort_data_before", data_o, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_data_o", data_o, 0);
    check("abort_busy", busy, 0);
    check("abort_pending", pending, 0);
    check("abort_overflow", overflow, 0);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    step(3);
    check("post_reset_busy", busy, 0);
    check("final_outstanding", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
